// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master picorv32 memory-bus arbiter:
// state encoding, the default error word and the MMIO addresses the benches use.
package mem_bus_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      OWN0 = ST_OWN0,
      OWN1 = ST_OWN1
   } state_e;

   localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

   localparam logic [31:0] MMIO_EXIT    = 32'h80000000;
   localparam logic [31:0] MMIO_CONSOLE = 32'h90000000;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Native memory bus bundle: two requester ports and the shared memory port.
// The arbiter takes the slave view; the requesters and memory model take master.
interface mem_bus_arbiter_if;

   logic        m0_mem_valid, m1_mem_valid;
   logic [31:0] m0_mem_addr,  m1_mem_addr;
   logic [31:0] m0_mem_wdata, m1_mem_wdata;
   logic [3:0]  m0_mem_wstrb, m1_mem_wstrb;
   logic        m0_mem_ready, m1_mem_ready;
   logic [31:0] m0_mem_rdata, m1_mem_rdata;

   logic        s_mem_valid;
   logic [31:0] s_mem_addr;
   logic [31:0] s_mem_wdata;
   logic [3:0]  s_mem_wstrb;
   logic        s_mem_ready;
   logic [31:0] s_mem_rdata;

   modport slave (
      input  m0_mem_valid, m0_mem_addr, m0_mem_wdata, m0_mem_wstrb,
      input  m1_mem_valid, m1_mem_addr, m1_mem_wdata, m1_mem_wstrb,
      output m0_mem_ready, m0_mem_rdata, m1_mem_ready, m1_mem_rdata,
      output s_mem_valid, s_mem_addr, s_mem_wdata, s_mem_wstrb,
      input  s_mem_ready, s_mem_rdata
   );

   modport master (
      output m0_mem_valid, m0_mem_addr, m0_mem_wdata, m0_mem_wstrb,
      output m1_mem_valid, m1_mem_addr, m1_mem_wdata, m1_mem_wstrb,
      input  m0_mem_ready, m0_mem_rdata, m1_mem_ready, m1_mem_rdata,
      input  s_mem_valid, s_mem_addr, s_mem_wdata, s_mem_wstrb,
      output s_mem_ready, s_mem_rdata
   );

endinterface

// File: rtl/mem_bus_watchdog.sv
// Slave-response watchdog: counts stalled owned cycles and flags expiry
// at TIMEOUT-1. TIMEOUT=0 never expires.
module mem_bus_watchdog #(
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expire = (TIMEOUT > 0) && (cnt_q == LIMIT);

   // Holding at LIMIT is safe: the arbiter always leaves the owned state on expiry.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && !expire)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus.
// One transaction per grant, one IDLE arbitration cycle, watchdog-forced completion.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int          TIMEOUT  = 256,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEF,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   mem_bus_arbiter_if.slave bus,
   output logic             timeout_err,
   output logic [1:0]       grant
);

   logic [1:0]       req_v;
   logic [1:0][31:0] req_addr;
   logic [1:0][31:0] req_wdata;
   logic [1:0][3:0]  req_wstrb;

   assign req_v     = {bus.m1_mem_valid, bus.m0_mem_valid};
   assign req_addr  = {bus.m1_mem_addr,  bus.m0_mem_addr};
   assign req_wdata = {bus.m1_mem_wdata, bus.m0_mem_wdata};
   assign req_wstrb = {bus.m1_mem_wstrb, bus.m0_mem_wstrb};

   state_e      state_q, state_d;
   logic        last_q, last_d;
   logic        own, sel, cur_v, expire, tmo, s_valid, done;
   logic        wd_clr, wd_en;
   logic [31:0] rsp_data;

   // A real s_mem_ready in the expiry cycle beats the watchdog.
   always_comb begin
      own      = (state_q != IDLE);
      sel      = (state_q == OWN1);
      cur_v    = own & req_v[sel];
      tmo      = cur_v & expire & ~bus.s_mem_ready;
      s_valid  = cur_v & ~tmo;
      done     = (s_valid & bus.s_mem_ready) | tmo;
      rsp_data = tmo ? ERR_DATA : bus.s_mem_rdata;
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (req_v == 2'b11)
               state_d = last_q ? OWN0 : OWN1;
            else if (req_v[0])
               state_d = OWN0;
            else if (req_v[1])
               state_d = OWN1;
         end
         OWN0, OWN1: begin
            if (done) begin
               state_d = IDLE;
               last_d  = sel;
            end else if (!cur_v) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      wd_clr = (state_d == IDLE);
      wd_en  = own & ~bus.s_mem_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   mem_bus_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_wdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (wd_clr),
      .en     (wd_en),
      .expire (expire)
   );

   assign grant       = {state_q == OWN1, state_q == OWN0};
   assign timeout_err = tmo;

   assign bus.s_mem_valid  = s_valid;
   assign bus.s_mem_addr   = own ? req_addr[sel]  : '0;
   assign bus.s_mem_wdata  = own ? req_wdata[sel] : '0;
   assign bus.s_mem_wstrb  = own ? req_wstrb[sel] : '0;

   assign bus.m0_mem_ready = grant[0] & done;
   assign bus.m1_mem_ready = grant[1] & done;
   assign bus.m0_mem_rdata = grant[0] ? rsp_data : '0;
   assign bus.m1_mem_rdata = grant[1] ? rsp_data : '0;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the picorv32 native memory bus (valid/ready, addr, wdata, wstrb, rdata).
- Lets the core (m0) and a second requester (m1: firmware loader / DMA / debug port) share the single on-chip memory.
- Round-robin fair, one transaction per grant, with a slave-response watchdog.
- Sits between the requesters and the memory model; address decode stays downstream.

Parameters:
- TIMEOUT, 256: cycles a granted transaction may wait for s_mem_ready before forced error completion; 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF: rdata returned to the master on timeout.
- CNT_W, 16: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_mem_valid, m1_mem_valid  in  1  request valid per master.
- m0_mem_addr, m1_mem_addr  in  32  address per master.
- m0_mem_wdata, m1_mem_wdata  in  32  write data per master.
- m0_mem_wstrb, m1_mem_wstrb  in  4  byte write strobes per master; 0 = read.
- m0_mem_ready, m1_mem_ready  out  1  completion to master.
- m0_mem_rdata, m1_mem_rdata  out  32  read data to master.
- s_mem_valid  out  1  request to memory.
- s_mem_addr  out  32  address to memory.
- s_mem_wdata  out  32  write data to memory.
- s_mem_wstrb  out  4  byte write strobes to memory.
- s_mem_ready  in  1  memory completion.
- s_mem_rdata  in  32  memory read data.
- timeout_err  out  1  one-cycle pulse on watchdog completion.
- grant  out  2  one-hot current owner; 2'b00 when idle.

Behaviour:
- Reset: state IDLE, grant=0, last=1 (so m0 wins the first tie), counter=0. All outputs read 0 during reset: s_mem_valid/addr/wdata/wstrb, m*_mem_ready, m*_mem_rdata, timeout_err.
- FSM states: IDLE, OWN0, OWN1.
- IDLE transitions:
  - only m0 valid -> OWN0.
  - only m1 valid -> OWN1.
  - both valid -> grant the master != last.
  - No slave request is issued in the IDLE cycle, giving 1 cycle of arbitration latency.
- OWNx datapath (combinational from grant):
  - s_mem_valid = mx_mem_valid; s_mem_addr/wdata/wstrb = master x fields.
  - mx_mem_ready = s_mem_ready & s_mem_valid.
  - mx_mem_rdata = s_mem_rdata.
  - The non-granted master sees ready=0, rdata=0.
  - Slave outputs are 0 whenever grant=0.
- Completion: on the cycle of mx_mem_ready=1, next state is IDLE, last<=x, counter<=0. Minimum transaction is 2 cycles (IDLE + 1 granted cycle).
- Grant hold: grant is never changed mid-transaction, even if the other master asserts valid.
- Abort: if the granted master deasserts valid before ready, return to IDLE next cycle and leave last unchanged.
- Watchdog (TIMEOUT>0):
  - Counter increments each OWNx cycle without s_mem_ready.
  - When counter==TIMEOUT-1 and still no ready: mx_mem_ready=1, mx_mem_rdata=ERR_DATA, timeout_err=1 for that cycle, s_mem_valid forced 0 that cycle, next state IDLE, last<=x.
  - If s_mem_ready arrives in that same cycle, the real response wins: no error, normal rdata.
- A late s_mem_ready while IDLE is ignored (no master ready).
- Asynchronous reset mid-transaction: immediately returns to reset values. The in-flight transaction is dropped with no ready.
- Width rules: all data paths pass through unmodified; the counter saturates conceptually at TIMEOUT-1 because the exit is forced there.

Decomposition:
- Shared package mem_bus_pkg:
  - state encoding localparams (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2);
  - ERR_DATA default;
  - MMIO constants used by benches: 32'h80000000 end-of-sim, 32'h90000000 console.
- One natural sub-module: mem_bus_watchdog (counter + expiry compare, with clear/enable inputs and an expire output).
- The mux stays inline.

Test Plan:
1. Single m0 read, memory ready 1 cycle after valid, s_mem_rdata=32'h12345678 -> grant=01 the cycle after valid; m0_mem_ready pulses once with rdata 32'h12345678; m1 sees ready=0.
2. Both masters valid from reset, each issuing 4 back-to-back writes (wstrb=4'hF) -> grants alternate 01,10,01,10… starting with m0; no slave cycle ever carries the non-owner's addr/wdata.
3. m0 owns, slave stalls 5 cycles, m1 raises valid at stall cycle 2 -> grant stays 01 until m0_mem_ready, then goes to 10 after one IDLE cycle.
4. TIMEOUT=8, slave never ready, m1 read -> m1_mem_ready and timeout_err both high exactly 8 cycles after grant; rdata=32'hDEADBEEF; s_mem_valid=0 that cycle; the next tie goes to m0.
5. Slave ready coincides with the expiry cycle -> normal rdata returned and timeout_err stays 0.
6. rst_n pulled low mid-stall with m0 granted -> grant=00, s_mem_valid=0 and all readies 0 immediately. After release with both valid, m0 is granted first.
